ibex_rf_write_arbiter: RTL
==========================

Name: ibex_rf_write_arbiter

Overview:
- Sequences the single write port of the flip-flop register file (we/waddr/wdata) between two writeback requesters.
- Requester 0 is the primary ALU/ID writeback; requester 1 is the late LSU load return.
- Fixed priority to requester 0, with a wait counter that guarantees requester 1 forward progress.
- Also runs a clear sequence that writes WordZeroVal to every implemented register (1..NUM_WORDS-1) for security wipe or boot.

Parameters:
- RV32E, 0, selects 16 words (ADDR_WIDTH 4) instead of 32 (ADDR_WIDTH 5); NUM_WORDS = 2**ADDR_WIDTH.
- DataWidth, 32, write data width.
- MaxWait, 3, cycles requester 1 may lose contention before it wins; legal range 1..15.
- WordZeroVal, '0, data written during the clear sequence.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clr_req_i  in  1  start clear-sequence request.
- clr_busy_o  out  1  clear sequence in progress.
- clr_done_o  out  1  one-cycle pulse at completion of clear.
- req0_valid_i  in  1  requester 0 write valid.
- req0_ready_o  out  1  requester 0 accepted.
- req0_addr_i  in  5  requester 0 destination register.
- req0_data_i  in  DataWidth  requester 0 write data.
- req1_valid_i  in  1  requester 1 write valid.
- req1_ready_o  out  1  requester 1 accepted.
- req1_addr_i  in  5  requester 1 destination register.
- req1_data_i  in  DataWidth  requester 1 write data.
- rf_we_o  out  1  register-file write enable (registered).
- rf_waddr_o  out  5  register-file write address (registered).
- rf_wdata_o  out  DataWidth  register-file write data (registered).

Behaviour:
- Reset: state ARB, wait_cnt 0, clear counter 0.
  - All outputs 0: rf_we_o, rf_waddr_o, rf_wdata_o, clr_busy_o, clr_done_o.
  - Ready outputs are 0 during reset.
- States are ARB and CLEAR.
- Handshake: a transfer occurs when valid && ready. ready is combinational from valid, state and wait_cnt. Requesters hold addr/data stable while valid && !ready.
- ARB grant rules:
  - req1 wins if req1_valid_i && (!req0_valid_i || wait_cnt == MaxWait).
  - Otherwise req0 wins if req0_valid_i.
  - At most one ready is high per cycle.
- wait_cnt:
  - Increments (saturating at MaxWait) when req1_valid_i && !req1_ready_o in ARB.
  - Clears to 0 on a req1 grant, or in any cycle req1_valid_i is low.
- Write latency: a grant in cycle N drives rf_we_o=1 with that requester's addr/data in cycle N+1. With no grant, rf_we_o=0 in N+1 and addr/data hold their last values.
- Addresses are forwarded unmodified, including x0. For RV32E, the upper address bit is forwarded as received.
- Clear request:
  - clr_req_i high in ARB takes precedence: both readies are 0 that cycle, and next state is CLEAR with counter=1. wait_cnt is held.
  - clr_req_i is ignored while in CLEAR.
- CLEAR state:
  - Both readies are 0 and clr_busy_o=1.
  - Each cycle issues counter k; next cycle rf_we_o=1, rf_waddr_o=k, rf_wdata_o=WordZeroVal.
  - Counter increments each cycle. After issuing NUM_WORDS-1, the block returns to ARB.
  - clr_done_o=1 in the same cycle rf_waddr_o=NUM_WORDS-1 is driven with the final clear write.
  - Total duration is NUM_WORDS-1 cycles of CLEAR. Address 0 is never cleared.
  - The first ARB cycle after CLEAR may grant immediately.
- Reset mid-clear: abort immediately to reset values; no clr_done_o pulse.
- Combinational paths from req*_valid_i to ready outputs are allowed. Paths from inputs to rf_* outputs are not.

Test Plan:
- Reset held then released, no requests → all outputs 0. Then req0 valid, addr 5, data 0xDEADBEEF → req0_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
- Both valid continuously, MaxWait=3 → req0 granted cycles 0-2, req1 granted cycle 3, wait_cnt back to 0. Pattern repeats every 4 cycles, with exactly one rf write per cycle.
- req1 alone, addr 31, data 0x1 → granted same cycle, write seen next cycle. Then req1 drops for one cycle → wait_cnt cleared (checked via contention resuming full 3-cycle req0 priority).
- clr_req_i pulse with RV32E=0 while both requesters valid → no grants for 32 cycles (request cycle + 31 CLEAR cycles). rf writes to addresses 1..31 with WordZeroVal in order; clr_done_o high only with waddr 31; grants resume after.
- RV32E=1 clear → writes to 1..15 only; clr_done_o with waddr 15. Assert rst_i during write of address 7 → outputs 0 immediately, no done pulse, state ARB after release.
- clr_req_i reasserted during CLEAR, and req0 addr 0 write → re-request ignored (single done pulse). Write to address 0 forwarded with rf_waddr_o=0.

Source files
------------

// File: rtl/ibex_rf_write_arbiter.sv
// Write-port sequencer for the flip-flop register file.
// It picks between two writeback requesters with fixed priority to requester 0.
// A wait counter guarantees forward progress for requester 1.
// It also runs a clear sequence that overwrites words 1..NUM_WORDS-1.
module ibex_rf_write_arbiter #(
  parameter bit                    RV32E       = 1'b0,
  parameter int unsigned           DataWidth   = 32,
  parameter int unsigned           MaxWait     = 3,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [4:0]           req0_addr_i,
  input  logic [DataWidth-1:0] req0_data_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [4:0]           req1_addr_i,
  input  logic [DataWidth-1:0] req1_data_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned          AddrWidth  = RV32E ? 4 : 5;
  localparam int unsigned          NumWords   = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastWord   = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] FirstWord  = AddrWidth'(1);
  localparam logic [3:0]           MaxWaitCnt = 4'(MaxWait);

  typedef enum logic {ARB, CLEAR} state_e;

  state_e               state, state_next;
  logic [3:0]           wait_cnt, wait_cnt_next;
  logic [AddrWidth-1:0] clr_cnt, clr_cnt_next;
  logic                 grant0, grant1, clr_last;

  // Next state, grants and clear counter advance; a clear request pre-empts all grants.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    grant0       = 1'b0;
    grant1       = 1'b0;
    clr_last     = 1'b0;
    case (state)
      ARB: begin
        if (clr_req_i) begin
          state_next   = CLEAR;
          clr_cnt_next = FirstWord;
        end else if (req1_valid_i && (!req0_valid_i || wait_cnt == MaxWaitCnt)) begin
          grant1 = 1'b1;
        end else if (req0_valid_i) begin
          grant0 = 1'b1;
        end
      end
      CLEAR: begin
        clr_last     = (clr_cnt == LastWord);
        clr_cnt_next = clr_cnt + FirstWord;
        if (clr_last) begin
          state_next   = ARB;
          clr_cnt_next = '0;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Wait counter: counts lost contentions of requester 1 and is cleared whenever it is idle.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!req1_valid_i) begin
      wait_cnt_next = '0;
    end else if (state == ARB && !clr_req_i) begin
      if (grant1)                     wait_cnt_next = '0;
      else if (wait_cnt < MaxWaitCnt) wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  // Readies are forced low while reset is asserted, because the state already reads ARB then.
  assign req0_ready_o = grant0 && !rst_i;
  assign req1_ready_o = grant1 && !rst_i;
  assign clr_busy_o   = (state == CLEAR);

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ARB;
      wait_cnt <= '0;
      clr_cnt  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      clr_cnt  <= clr_cnt_next;
    end
  end

  // Registered write port. Address and data hold their value when nothing is written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      clr_done_o <= 1'b0;
    end else begin
      rf_we_o    <= grant0 || grant1 || (state == CLEAR);
      clr_done_o <= clr_last;
      if (grant1) begin
        rf_waddr_o <= req1_addr_i;
        rf_wdata_o <= req1_data_i;
      end else if (grant0) begin
        rf_waddr_o <= req0_addr_i;
        rf_wdata_o <= req0_data_i;
      end else if (state == CLEAR) begin
        rf_waddr_o <= 5'(clr_cnt);
        rf_wdata_o <= WordZeroVal;
      end
    end
  end

endmodule
